// File: rtl/sprite_cmd_encoder.sv
// Shadow sprite table serialised into one command word per cycle after frame_start (first word 1 cycle later, no stalls).
// Build macro SPRITE_CMD_SKIP_HIDDEN_EN: hidden sprites emit only their attr word.
module sprite_cmd_encoder #(
  parameter logic [5:0] COMPONENT_ID = 6'b000001,
  parameter int         NUM_CHILD    = 4,
  parameter int         PATTERN_NUM  = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_child,
  input  logic [2:0]  cfg_field,
  input  logic [12:0] cfg_data,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        front_buf,
  output logic        overrun,
  output logic        cfg_err
);

`ifdef SPRITE_CMD_SKIP_HIDDEN_EN
  localparam bit SKIP_HIDDEN = 1'b1;
`else
  localparam bit SKIP_HIDDEN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ATTR, XPOS, YPOS, SHIFT, SWAP} state_t;

  localparam logic [2:0] F_ATTR  = 3'd1;
  localparam logic [2:0] F_X     = 3'd2;
  localparam logic [2:0] F_Y     = 3'd3;
  localparam logic [2:0] F_SHIFT = 3'd4;

  logic       vis_q   [NUM_CHILD];
  logic       flip_q  [NUM_CHILD];
  logic [4:0] pat_q   [NUM_CHILD];
  logic [9:0] x_q     [NUM_CHILD];
  logic [9:0] y_q     [NUM_CHILD];
  logic [9:0] shift_q [NUM_CHILD];

  state_t     state;
  logic [4:0] child;
  logic       back;
  logic       cur_vis;

  logic [4:0] rd_idx;
  logic       rd_vis;
  logic       rd_flip;
  logic [4:0] rd_pat;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic [9:0] rd_shift;
  logic       do_adv;
  logic       last_child;
  logic       cfg_hit;
  logic       pat_ok;
  logic       unused_cfg_bits;

  assign cfg_hit         = cfg_we && (32'(cfg_child) < NUM_CHILD);
  assign pat_ok          = 32'(cfg_data[4:0]) < PATTERN_NUM;
  assign last_child      = 32'(child) >= NUM_CHILD - 1;
  assign unused_cfg_bits = ^cfg_data[10:5];

  function automatic logic [31:0] field_word(input logic [4:0] c, input logic [2:0] t,
                                             input logic b, input logic [12:0] msg);
    return {COMPONENT_ID, c, 4'b0001, t, b, msg};
  endfunction

  // Shadow table; a bad attr pattern drops the whole attr write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_CHILD; i++) begin
        vis_q[i]   <= 1'b0;
        flip_q[i]  <= 1'b0;
        pat_q[i]   <= 5'd0;
        x_q[i]     <= 10'd0;
        y_q[i]     <= 10'd0;
        shift_q[i] <= 10'd0;
      end
    end else if (cfg_hit) begin
      if (cfg_field == F_ATTR && !pat_ok)
        cfg_err <= 1'b1;
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (cfg_child == i[4:0]) begin
          case (cfg_field)
            F_ATTR: begin
              if (pat_ok) begin
                vis_q[i]  <= cfg_data[12];
                flip_q[i] <= cfg_data[11];
                pat_q[i]  <= cfg_data[4:0];
              end
            end
            F_X:     x_q[i]     <= cfg_data[9:0];
            F_Y:     y_q[i]     <= cfg_data[9:0];
            F_SHIFT: shift_q[i] <= cfg_data[9:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Advancing reads the next child's attr ahead of its word being registered.
  always_comb begin
    do_adv = (state == SHIFT) || (state == ATTR && SKIP_HIDDEN && !cur_vis);
    if (state == IDLE)
      rd_idx = 5'd0;
    else if (do_adv)
      rd_idx = child + 5'd1;
    else
      rd_idx = child;
  end

  always_comb begin
    rd_vis   = 1'b0;
    rd_flip  = 1'b0;
    rd_pat   = 5'd0;
    rd_x     = 10'd0;
    rd_y     = 10'd0;
    rd_shift = 10'd0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (rd_idx == i[4:0]) begin
        rd_vis   = vis_q[i];
        rd_flip  = flip_q[i];
        rd_pat   = pat_q[i];
        rd_x     = x_q[i];
        rd_y     = y_q[i];
        rd_shift = shift_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      child     <= 5'd0;
      back      <= 1'b0;
      cur_vis   <= 1'b0;
      writedata <= 32'h0;
      busy      <= 1'b0;
      front_buf <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_start && state != IDLE)
        overrun <= 1'b1;
      if (do_adv) begin
        if (last_child) begin
          writedata <= {11'd0, 4'b1111, 3'd0, back, 13'd0};
          front_buf <= back;
          state     <= SWAP;
        end else begin
          child     <= rd_idx;
          cur_vis   <= rd_vis;
          writedata <= field_word(rd_idx, F_ATTR, back, {rd_vis, rd_flip, 6'd0, rd_pat});
          state     <= ATTR;
        end
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              back      <= ~front_buf;
              child     <= 5'd0;
              cur_vis   <= rd_vis;
              writedata <= field_word(rd_idx, F_ATTR, ~front_buf, {rd_vis, rd_flip, 6'd0, rd_pat});
              busy      <= 1'b1;
              state     <= ATTR;
            end
          end
          ATTR: begin
            writedata <= field_word(rd_idx, F_X, back, {3'd0, rd_x});
            state     <= XPOS;
          end
          XPOS: begin
            writedata <= field_word(rd_idx, F_Y, back, {3'd0, rd_y});
            state     <= YPOS;
          end
          YPOS: begin
            writedata <= field_word(rd_idx, F_SHIFT, back, {3'd0, rd_shift});
            state     <= SHIFT;
          end
          SWAP: begin
            writedata <= 32'h0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
